// File: rtl/tzeros_pkg.sv
// tzeros_pkg -- shared constants and helpers for the trailing-zero counter.
//   TZ_DATA_WIDTH : default input word width
//   tz_out_w(w)   : result width able to hold 0..w inclusive ($clog2(w)+1)
package tzeros_pkg;

  localparam int TZ_DATA_WIDTH = 8;

  // One extra bit over $clog2 so the all-zeros result (== w) fits even
  // when w is a power of two.
  function automatic int tz_out_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/tzeros_enc.sv
// tzeros_enc -- combinational trailing-zero priority encoder.
// Ports:
//   din_i [DATA_WIDTH-1:0]  word to examine
//   cnt_o [OUT_W-1:0]       index of lowest set bit, or DATA_WIDTH if none
module tzeros_enc
  import tzeros_pkg::*;
#(
  parameter int DATA_WIDTH = TZ_DATA_WIDTH,
  localparam int OUT_W     = tz_out_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [OUT_W-1:0]      cnt_o
);

  // Scan MSB->LSB so the lowest set bit is the last to assign and wins.
  always_comb begin
    cnt_o = OUT_W'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (din_i[i]) cnt_o = OUT_W'(i);
    end
  end

endmodule

// File: rtl/tzeros.sv
// tzeros -- registered trailing-zero counter, one cycle of latency.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   din_valid, din      qualified input word (din ignored while !din_valid)
//   dout_valid          high the cycle after a valid input was captured
//   dout                trailing-zero count, held across idle cycles
//   dout_zero           (TZEROS_ZERO_FLAG_EN only) captured word was all zeros
// Build option: define TZEROS_ZERO_FLAG_EN to add the dout_zero output.
module tzeros
  import tzeros_pkg::*;
#(
  parameter int DATA_WIDTH = TZ_DATA_WIDTH,
  localparam int OUT_W     = tz_out_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout_valid,
`ifdef TZEROS_ZERO_FLAG_EN
  output logic                  dout_zero,
`endif
  output logic [OUT_W-1:0]      dout
);

  logic [OUT_W-1:0] cnt;
  logic             vld_q, vld_d;
  logic [OUT_W-1:0] dout_q, dout_d;

  tzeros_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .din_i (din),
    .cnt_o (cnt)
  );

  // Result only moves on a valid input; X on din while idle never reaches
  // the register because the mux selects the held value.
  assign vld_d  = din_valid;
  assign dout_d = din_valid ? cnt : dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign dout_valid = vld_q;
  assign dout       = dout_q;

`ifdef TZEROS_ZERO_FLAG_EN
  logic zero_q, zero_d;

  assign zero_d = din_valid ? (cnt == OUT_W'(DATA_WIDTH)) : zero_q;

  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign dout_zero = zero_q;
`endif

endmodule

// File: tb/tb_tzeros.sv
module tb_tzeros;

  localparam int W8  = 8;
  localparam int O8  = 4;
  localparam int W16 = 16;
  localparam int O16 = 5;

  logic clk = 1'b0;
  logic rst;
  logic           v8, v16;
  logic [W8-1:0]  d8;
  logic [W16-1:0] d16;
  logic           ov8, ov16;
  logic [O8-1:0]  o8;
  logic [O16-1:0] o16;
`ifdef TZEROS_ZERO_FLAG_EN
  logic z8, z16;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tzeros #(.DATA_WIDTH(W8)) u8 (
    .clk(clk), .rst(rst), .din_valid(v8), .din(d8),
    .dout_valid(ov8),
`ifdef TZEROS_ZERO_FLAG_EN
    .dout_zero(z8),
`endif
    .dout(o8)
  );

  tzeros #(.DATA_WIDTH(W16)) u16 (
    .clk(clk), .rst(rst), .din_valid(v16), .din(d16),
    .dout_valid(ov16),
`ifdef TZEROS_ZERO_FLAG_EN
    .dout_zero(z16),
`endif
    .dout(o16)
  );

  // Reference: walk up from bit 0 counting zeros until a one or the top.
  function automatic int ref_tz(input logic [31:0] v, input int w);
    int n = 0;
    while (n < w && v[n] == 1'b0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v8 = 1'b1; d8 = 8'h80; v16 = 1'b1; d16 = 16'h0100;
    step();
    tests++;
    if (ov8 !== 1'b0 || o8 !== 4'd0) begin
      fails++; $display("FAIL reset8: got vld=%b dout=%0d, want vld=0 dout=0", ov8, o8);
    end
    tests++;
    if (ov16 !== 1'b0 || o16 !== 5'd0) begin
      fails++; $display("FAIL reset16: got vld=%b dout=%0d, want vld=0 dout=0", ov16, o16);
    end
`ifdef TZEROS_ZERO_FLAG_EN
    tests++;
    if (z8 !== 1'b0 || z16 !== 1'b0) begin
      fails++; $display("FAIL reset_zero: got z8=%b z16=%b, want 0 0", z8, z16);
    end
`endif
    rst = 1'b0; v8 = 1'b0; v16 = 1'b0;
    step();
    tests++;
    if (ov8 !== 1'b0 || o8 !== 4'd0) begin
      fails++; $display("FAIL reset_drop: got vld=%b dout=%0d, want vld=0 dout=0", ov8, o8);
    end
  endtask

  task automatic test_sequence();
    logic [W8-1:0] seq [4];
    int            exp [4];
    seq = '{8'b1000_0000, 8'b1000_1000, 8'b1111_1111, 8'b0000_0000};
    exp = '{7, 3, 0, 8};
    for (int i = 0; i < 4; i++) begin
      v8 = 1'b1; d8 = seq[i];
      step();
      tests++;
      if (ov8 !== 1'b1 || o8 !== O8'(exp[i])) begin
        fails++; $display("FAIL seq[%0d]: got vld=%b dout=%0d, want vld=1 dout=%0d", i, ov8, o8, exp[i]);
      end
    end
    v8 = 1'b0;
    step();
  endtask

  task automatic test_onehot();
    logic [W8-1:0] one;
    for (int k = 0; k < W8; k++) begin
      one = '0; one[k] = 1'b1;
      v8 = 1'b1; d8 = one;
      step();
      tests++;
      if (ov8 !== 1'b1 || o8 !== O8'(k)) begin
        fails++; $display("FAIL onehot k=%0d: got vld=%b dout=%0d, want vld=1 dout=%0d", k, ov8, o8, k);
      end
    end
    v8 = 1'b0;
    step();
  endtask

  task automatic test_hold();
    v8 = 1'b1; d8 = 8'hAA;
    step();
    tests++;
    if (ov8 !== 1'b1 || o8 !== 4'd1) begin
      fails++; $display("FAIL hold_load: got vld=%b dout=%0d, want vld=1 dout=1", ov8, o8);
    end
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d8 = 8'($urandom);
      step();
      tests++;
      if (ov8 !== 1'b0 || o8 !== 4'd1) begin
        fails++; $display("FAIL hold[%0d]: got vld=%b dout=%0d, want vld=0 dout=1", i, ov8, o8);
      end
    end
  endtask

  task automatic test_reset_mid();
    v8 = 1'b1; d8 = 8'h04;
    step();
    tests++;
    if (o8 !== 4'd2) begin
      fails++; $display("FAIL mid_pre: got dout=%0d, want 2", o8);
    end
    rst = 1'b1; d8 = 8'h10;
    step();
    tests++;
    if (ov8 !== 1'b0 || o8 !== 4'd0) begin
      fails++; $display("FAIL mid_rst: got vld=%b dout=%0d, want vld=0 dout=0", ov8, o8);
    end
    rst = 1'b0; v8 = 1'b0;
    step();
    tests++;
    if (ov8 !== 1'b0 || o8 !== 4'd0) begin
      fails++; $display("FAIL mid_drop: got vld=%b dout=%0d, want vld=0 dout=0", ov8, o8);
    end
    v8 = 1'b1; d8 = 8'h20;
    step();
    tests++;
    if (ov8 !== 1'b1 || o8 !== 4'd5) begin
      fails++; $display("FAIL mid_first: got vld=%b dout=%0d, want vld=1 dout=5", ov8, o8);
    end
    v8 = 1'b0;
    step();
  endtask

  task automatic test_w16();
    logic [W16-1:0] vals [3];
    int             exp  [3];
    vals = '{16'h0000, 16'h8000, 16'h0001};
    exp  = '{16, 15, 0};
    for (int i = 0; i < 3; i++) begin
      v16 = 1'b1; d16 = vals[i];
      step();
      tests++;
      if (ov16 !== 1'b1 || o16 !== O16'(exp[i])) begin
        fails++; $display("FAIL w16[%0d]: got vld=%b dout=%0d, want vld=1 dout=%0d", i, ov16, o16, exp[i]);
      end
`ifdef TZEROS_ZERO_FLAG_EN
      tests++;
      if (z16 !== (exp[i] == W16)) begin
        fails++; $display("FAIL w16_zero[%0d]: got %b, want %b", i, z16, exp[i] == W16);
      end
`endif
    end
    v16 = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      v8 = 1'b1; d8 = 8'(i);
      step();
      tests++;
      if (ov8 !== 1'b1 || o8 !== O8'(ref_tz(32'(i), W8))) begin
        fails++; $display("FAIL sweep %02h: got vld=%b dout=%0d, want vld=1 dout=%0d", i, ov8, o8, ref_tz(32'(i), W8));
      end
    end
    v8 = 1'b0;
    step();
  endtask

  // Random mix of valid/idle on both widths, with X driven while idle.
  task automatic test_random();
    int  e8, e16;
    bit  ev8, ev16;
    bit  ez8, ez16;
    logic [W16-1:0] r;
    e8 = int'(o8); e16 = int'(o16);
    ez8 = (e8 == W8); ez16 = (e16 == W16);
    for (int i = 0; i < 400; i++) begin
      ev8  = ($urandom_range(0, 3) != 0);
      ev16 = ($urandom_range(0, 3) != 0);
      r = 16'($urandom);
      r = r >> $urandom_range(0, 16);
      v8  = ev8;  d8  = ev8  ? 8'(r) : 'x;
      v16 = ev16; d16 = ev16 ? r     : 'x;
      if (ev8)  begin e8  = ref_tz(32'(r[7:0]), W8); ez8  = (e8  == W8);  end
      if (ev16) begin e16 = ref_tz(32'(r), W16);     ez16 = (e16 == W16); end
      step();
      tests++;
      if (ov8 !== ev8 || o8 !== O8'(e8) || ov16 !== ev16 || o16 !== O16'(e16)) begin
        fails++;
        $display("FAIL rand[%0d]: got v8=%b d8=%0d v16=%b d16=%0d, want v8=%b d8=%0d v16=%b d16=%0d",
                 i, ov8, o8, ov16, o16, ev8, e8, ev16, e16);
      end
`ifdef TZEROS_ZERO_FLAG_EN
      tests++;
      if (z8 !== ez8 || z16 !== ez16) begin
        fails++; $display("FAIL rand_zero[%0d]: got %b %b, want %b %b", i, z8, z16, ez8, ez16);
      end
`endif
    end
    v8 = 1'b0; v16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v8 = 1'b0; v16 = 1'b0; d8 = '0; d16 = '0;
    test_reset();
    test_sequence();
    test_onehot();
    test_hold();
    test_reset_mid();
    test_w16();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tzeros.md
TZEROS -- requirements
Module: tzeros

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the input word; legal values are 2 or more.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port din_valid, input, 1 bit: din is qualified this cycle.
REQ-006 SHALL have port din, input, DATA_WIDTH bits: word to examine.
REQ-007 SHALL have port dout_valid, output, 1 bit: dout holds a result.
REQ-008 SHALL have port dout, output, $clog2(DATA_WIDTH)+1 bits: number of trailing zeros of the captured din.
REQ-009 SHALL have port dout_zero, output, 1 bit, present only when TZEROS_ZERO_FLAG_EN is defined: captured din was all zeros.

Function
REQ-010 SHALL set dout to the count of consecutive zero bits starting at din[0] and moving toward the MSB, ending at the first 1 bit.
REQ-011 SHALL set dout = DATA_WIDTH when din is all zeros; the output width shall hold this value without overflow.
REQ-012 SHALL set dout = 0 whenever din[0] = 1, whatever the upper bits hold.
REQ-013 SHALL give exactly one cycle of latency: a din sampled with din_valid=1 at edge N appears on dout, with dout_valid=1, after edge N.
REQ-014 SHALL hold dout after a cycle with din_valid=0, and drive dout_valid=0 for that cycle.
REQ-015 SHALL, on back-to-back valid inputs, update the result every cycle; there is no backpressure input.
REQ-016 SHALL ignore din (including X values) while din_valid=0.
REQ-017 SHALL build the count combinationally as a priority encoder, with no iteration across cycles and no state machine.
REQ-018 SHALL zero-extend dout to its full width; unused upper bits are 0 unless the input is all zeros.

Reset
REQ-019 SHALL, while rst=1 at a clock edge, force dout=0 and dout_valid=0, and force dout_zero=0 when present.
REQ-020 SHALL drop any input sampled in the same cycle that rst is asserted; the first valid output appears one cycle after the first valid input following deassertion.

Configuration
REQ-021 SHALL add the registered output dout_zero when TZEROS_ZERO_FLAG_EN is defined; it is 1 exactly when the result equals DATA_WIDTH and updates under the same valid/hold rules as dout.
REQ-022 SHALL have no dout_zero port and no related logic when TZEROS_ZERO_FLAG_EN is not defined; all other behaviour is identical in both builds.

Structure
REQ-023 SHALL put in package tzeros_pkg: the DATA_WIDTH default constant and a function that gives the output width ($clog2(w)+1).
REQ-024 SHALL place the combinational trailing-zero priority encoder in sub-module tzeros_enc, parameterised by DATA_WIDTH; tzeros holds only the valid and output registers.

Verification
REQ-025 SHALL check, at DATA_WIDTH=8, the valid input sequence 8'b1000_0000, 8'b1000_1000, 8'b1111_1111, 8'b0000_0000: dout = 7, 3, 0, 8, each one cycle later.
REQ-026 SHALL check at DATA_WIDTH=8 that every single-hot value 1<<k gives dout=k, for k from 0 to 7.
REQ-027 SHALL check that din=8'hAA with din_valid=1, then din_valid=0 for 3 cycles, gives dout=1 held, with dout_valid=1 then 0, 0, 0.
REQ-028 SHALL check that asserting rst mid-stream with din=8'h10 valid gives dout=0 and dout_valid=0 the next cycle, and that the input is dropped.
REQ-029 SHALL check at DATA_WIDTH=16 with TZEROS_ZERO_FLAG_EN defined: din=16'h0000 gives dout=16 and dout_zero=1; din=16'h8000 gives dout=15 and dout_zero=0.
REQ-030 SHALL run an exhaustive sweep at DATA_WIDTH=8 of all 256 values, back-to-back valid, compared against a loop-based reference count.
